// File: rtl/comparator_with_bcs.sv
// comparator_with_bcs: registered unsigned A==B / A<B flags from an MSB-first slice chain
module comparator_with_bcs #(
    parameter int N             = 8,
    parameter bit TWO_BIT_SLICE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         EQ,
    output logic         LT
);
    logic eq_d, lt_d, eq_q, lt_q;

    generate
        if (TWO_BIT_SLICE) begin : g_tbcs
            localparam int M = (N + 1) / 2;
            logic [2*M-1:0] a_x, b_x;
            // zero-extend odd widths so every two-bit cell sees a full pair
            always_comb begin
                a_x = (2*M)'(A);
                b_x = (2*M)'(B);
            end
            // ripple of two-bit cells from the MSB pair down; lt uses the incoming eq
            always_comb begin
                eq_d = 1'b1;
                lt_d = 1'b0;
                for (int k = M - 1; k >= 0; k--) begin
                    lt_d = lt_d | (eq_d & (a_x[2*k +: 2] < b_x[2*k +: 2]));
                    eq_d = eq_d & (a_x[2*k +: 2] == b_x[2*k +: 2]);
                end
            end
        end else begin : g_bcs
            // ripple of one-bit cells from the MSB down; lt uses the incoming eq
            always_comb begin
                eq_d = 1'b1;
                lt_d = 1'b0;
                for (int k = N - 1; k >= 0; k--) begin
                    lt_d = lt_d | (eq_d & ~A[k] & B[k]);
                    eq_d = eq_d & ~(A[k] ^ B[k]);
                end
            end
        end
    endgenerate

    // output flags register the chain result; reset clears them asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
            lt_q <= lt_d;
        end
    end

    assign EQ = eq_q;
    assign LT = lt_q;
endmodule

// File: tb/tb_comparator_with_bcs.sv
// tb_comparator_with_bcs: scoreboard bench comparing both slice architectures at N=8 and N=7
module tb_comparator_with_bcs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [6:0] a7 = '0, b7 = '0;
    logic eq8b, lt8b, eq8t, lt8t, eq7b, lt7b, eq7t, lt7t;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] r8;
        logic [1:0] r7;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    comparator_with_bcs #(.N(8), .TWO_BIT_SLICE(1'b0)) dut8b (.clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .EQ(eq8b), .LT(lt8b));
    comparator_with_bcs #(.N(8), .TWO_BIT_SLICE(1'b1)) dut8t (.clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .EQ(eq8t), .LT(lt8t));
    comparator_with_bcs #(.N(7), .TWO_BIT_SLICE(1'b0)) dut7b (.clk(clk), .rst_n(rst_n), .A(a7), .B(b7), .EQ(eq7b), .LT(lt7b));
    comparator_with_bcs #(.N(7), .TWO_BIT_SLICE(1'b1)) dut7t (.clk(clk), .rst_n(rst_n), .A(a7), .B(b7), .EQ(eq7t), .LT(lt7t));

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {EQ,LT}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, " n8_bcs"}, {eq8b, lt8b}, e.r8);
        check({tag, " n8_tbcs"}, {eq8t, lt8t}, e.r8);
        check({tag, " n7_bcs"}, {eq7b, lt7b}, e.r7);
        check({tag, " n7_tbcs"}, {eq7t, lt7t}, e.r7);
    endtask

    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [6:0] c, input logic [6:0] d);
        exp_t e;
        @(negedge clk);
        a8 = a;
        b8 = b;
        a7 = c;
        b7 = d;
        sb.push_back('{r8: {a == b, a < b}, r7: {c == d, c < d}});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 2'b11, 2'b00);
        end else begin
            e = sb.pop_front();
            check_all(tag, e);
        end
    endtask

    initial begin
        logic [7:0] v;
        rst_n = 1'b0;
        a8 = 8'hFF;
        b8 = 8'hFF;
        a7 = 7'h7F;
        b7 = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("reset_release", 8'hFF, 8'hFF, 7'h7F, 7'h7F);

        for (int i = 7; i >= 0; i--) begin
            v = 8'hFF;
            v[i] = 1'b0;
            step("walk_a_clear", v, 8'hFF, v[6:0], 7'h7F);
            step("walk_a_restore", 8'hFF, 8'hFF, 7'h7F, 7'h7F);
        end

        step("a_gt_b", 8'hFF, 8'h00, 7'h7F, 7'h00);
        step("zero_eq", 8'h00, 8'h00, 7'h00, 7'h00);

        for (int i = 7; i >= 0; i--) begin
            v = 8'h00;
            v[i] = 1'b1;
            step("walk_b_set", 8'h00, v, 7'h00, v[6:0]);
            step("walk_b_clear", 8'h00, 8'h00, 7'h00, 7'h00);
        end

        for (int x = 0; x < 128; x++) begin
            for (int y = 0; y < 128; y++) begin
                step("sweep", 8'($urandom), 8'($urandom), 7'(x), 7'(y));
            end
        end

        for (int k = 0; k < 300; k++) begin
            v = 8'($urandom);
            if (k % 4 == 0) step("random_eq", v, v, v[6:0], v[6:0]);
            else step("random", v, 8'($urandom), 7'($urandom), 7'($urandom));
        end

        step("pre_async", 8'h10, 8'h20, 7'h10, 7'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_drop", '0);
        #1;
        rst_n = 1'b1;
        step("async_release", 8'h10, 8'h20, 7'h10, 7'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
